instr_decode_ctrl: RTL
======================

// Module: instr_decode_ctrl
// PURPOSE
// Multi-cycle fetch/decode/execute controller directly upstream of the 4x8 register file.
// - Fetches 8-bit instructions over a req/valid handshake and advances the PC.
// - Decodes the 2-bit register field into the one-hot RegNum and drives RegCE for register writes.
// - Drives AccCE/AluOp so the accumulator/ALU stage consumes the register file output.
// PARAMETERS
// PC_W      5      program counter width; wraps modulo 2**PC_W
// PC_RST    0      PC value loaded at reset
// PORTS
// clk        in   1     system clock, rising edge
// nReset     in   1     asynchronous active-low reset
// instr_req  out  1     request for the instruction at pc
// instr_vld  in   1     instr valid; accepted only while instr_req=1
// instr      in   8     instruction byte: [7:5] opcode, [4:3] reg, [2:0] imm3
// pc         out  PC_W  address of the next instruction to fetch
// RegNum     out  4     one-hot register select to register file (0 = none)
// RegCE      out  1     register file write enable (A -> selected register)
// AccCE      out  1     accumulator load enable
// AluOp      out  3     ALU op: 0 PASS_REG, 1 ADD, 2 SUB, 3 AND, 4 PASS_IMM
// Imm        out  8     {5'b0, imm3} zero-extended immediate
// halted     out  1     1 while in HALT
// BEHAVIOUR
// Reset (async, nReset=0): state=FETCH, IR=0, pc=PC_RST, instr_req=0, RegNum=0, RegCE=0,
//   AccCE=0, AluOp=0, Imm=0, halted=0. First cycle after release: instr_req=1.
// FSM: FETCH -> DECODE -> EXEC -> FETCH; HLT goes DECODE -> HALT (absorbing until reset).
// FETCH: instr_req=1. On a clock edge with instr_vld=1: IR<=instr, pc<=pc+1 (wrap
//   2**PC_W-1 -> 0), go DECODE. instr_vld=0: hold, pc unchanged. instr_vld with req=0 ignored.
// DECODE (1 cycle): instr_req=0; RegNum=onehot(IR[4:3]) (00->0001 .. 11->1000) so the
//   register file mux presents the selected register; RegCE=0, AccCE=0.
// EXEC (1 cycle): RegNum held; exactly one strobe per opcode:
//   000 NOP: no strobe. 001 MOV: RegCE=1 (write accumulator into Rn).
//   010 LDA: AccCE=1, AluOp=0. 011 ADD: AccCE=1, AluOp=1. 100 SUB: AccCE=1, AluOp=2.
//   101 AND: AccCE=1, AluOp=3. 110: see CONFIGURATION. 111 HLT: not reached (HALT).
//   LDI-type uses AccCE=1, AluOp=4, Imm valid in EXEC only.
// Outputs RegNum/RegCE/AccCE/AluOp/Imm registered (glitch-free); all zero outside DECODE/EXEC.
// RegCE and AccCE never both 1; each asserted for exactly one cycle per instruction.
// Latency: instruction accepted at edge N -> strobe high in cycle N+2 -> next instr_req at N+3.
// Throughput: one instruction per 3 cycles when instr_vld is tied high.
// HALT: halted=1, instr_req=0, all strobes 0, pc frozen at address after the HLT.
// Reset mid-instruction: all strobes drop immediately (async); no partial write completes.
// CONFIGURATION
// Macro ID_JMP_EN:
//   defined: opcode 110 = JMP; in EXEC pc <= {IR[4:0]} zero-extended/truncated to PC_W,
//     no strobes; next fetch uses new pc (overrides the fetch increment).
//   undefined: opcode 110 = LDI; EXEC drives AccCE=1, AluOp=4, Imm={5'b0,IR[2:0]}.
// TESTING
// 1 Reset: nReset=0 mid-EXEC of MOV -> RegCE=0 same cycle, pc=PC_RST, halted=0, req=1 after release.
// 2 MOV R2 (instr=8'h30), vld=1 -> DECODE RegNum=0100, EXEC RegNum=0100 RegCE=1, pc=1.
// 3 ADD R3 (8'h78) then SUB R0 (8'h80), vld tied 1 -> AccCE pulses with AluOp=1 then 2,
//   RegNum 1000 then 0001, 3 cycles apart.
// 4 Stall: vld=0 for 5 cycles in FETCH -> req stays 1, pc unchanged, all strobes 0.
// 5 Wrap: pc=31 (PC_W=5), fetch NOP -> pc=0; HLT (8'hE0) -> halted=1, req=0 for 20 cycles.
// 6 Op 110 instr=8'hD5: ID_JMP_EN -> pc=5'h15, no strobes; else AccCE=1, AluOp=4, Imm=8'h05.

Source files
------------

// File: rtl/instr_decode_ctrl_if.sv
// Instruction fetch port of instr_decode_ctrl: request/valid handshake, instruction
// byte and fetch address. master = controller side, slave = instruction memory side.
interface instr_decode_ctrl_if #(
    parameter int unsigned PC_W = 5
);
    logic            instr_req;
    logic            instr_vld;
    logic [7:0]      instr;
    logic [PC_W-1:0] pc;

    modport master (
        output instr_req,
        output pc,
        input  instr_vld,
        input  instr
    );

    modport slave (
        input  instr_req,
        input  pc,
        output instr_vld,
        output instr
    );
endinterface

// File: rtl/instr_decode_ctrl.sv
// Fetch/decode/execute controller feeding the 4x8 register file and accumulator/ALU.
// Build option: define ID_JMP_EN to make opcode 110 a JMP; otherwise it is LDI.
module instr_decode_ctrl #(
    parameter int unsigned          PC_W   = 5,
    parameter logic [PC_W-1:0]      PC_RST = '0
) (
    input  logic                    clk,
    input  logic                    nReset,
    instr_decode_ctrl_if.master     fetch,
    output logic [3:0]              RegNum,
    output logic                    RegCE,
    output logic                    AccCE,
    output logic [2:0]              AluOp,
    output logic [7:0]              Imm,
    output logic                    halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_MOV = 3'd1,
        OP_LDA = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_AND = 3'd5,
`ifdef ID_JMP_EN
        OP_JMP = 3'd6,
`else
        OP_LDI = 3'd6,
`endif
        OP_HLT = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_PASS_REG = 3'd0,
        ALU_ADD      = 3'd1,
        ALU_SUB      = 3'd2,
        ALU_AND      = 3'd3,
        ALU_PASS_IMM = 3'd4
    } alu_t;

    state_t          r_state;
    logic [7:0]      r_ir;
    logic [PC_W-1:0] r_pc;
    logic            r_req;
    logic [3:0]      r_regnum;
    logic            r_regce;
    logic            r_acce;
    alu_t            r_aluop;
    logic [7:0]      r_imm;
    logic            r_halted;

    opcode_t         w_op;
    logic            w_accept;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_regce;
    logic            w_acce;
    alu_t            w_aluop;
    logic [7:0]      w_imm;
`ifdef ID_JMP_EN
    logic [PC_W+4:0] w_jmp_ext;
    logic [PC_W-1:0] w_jmp_tgt;
`endif

    function automatic logic [3:0] onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

    assign w_op     = opcode_t'(r_ir[7:5]);
    assign w_accept = (r_state == S_FETCH) && r_req && fetch.instr_vld;
    assign w_pc_inc = r_pc + PC_W'(1);

`ifdef ID_JMP_EN
    // Zero-extend the 5-bit target, then keep only PC_W bits (truncates when PC_W < 5).
    assign w_jmp_ext = {{PC_W{1'b0}}, r_ir[4:0]};
    assign w_jmp_tgt = w_jmp_ext[PC_W-1:0];
`endif

    // Strobe pattern for the EXEC cycle, loaded into the output registers on leaving DECODE.
    always_comb begin
        w_regce = 1'b0;
        w_acce  = 1'b0;
        w_aluop = ALU_PASS_REG;
        w_imm   = '0;
        case (w_op)
            OP_MOV: w_regce = 1'b1;
            OP_LDA: w_acce  = 1'b1;
            OP_ADD: begin
                w_acce  = 1'b1;
                w_aluop = ALU_ADD;
            end
            OP_SUB: begin
                w_acce  = 1'b1;
                w_aluop = ALU_SUB;
            end
            OP_AND: begin
                w_acce  = 1'b1;
                w_aluop = ALU_AND;
            end
`ifndef ID_JMP_EN
            OP_LDI: begin
                w_acce  = 1'b1;
                w_aluop = ALU_PASS_IMM;
                w_imm   = {5'b0, r_ir[2:0]};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state  <= S_FETCH;
            r_ir     <= '0;
            r_pc     <= PC_RST;
            r_req    <= 1'b0;
            r_regnum <= '0;
            r_regce  <= 1'b0;
            r_acce   <= 1'b0;
            r_aluop  <= ALU_PASS_REG;
            r_imm    <= '0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_accept) begin
                        r_ir     <= fetch.instr;
                        r_pc     <= w_pc_inc;
                        r_req    <= 1'b0;
                        r_regnum <= onehot(fetch.instr[4:3]);
                        r_state  <= S_DECODE;
                    end else begin
                        r_req    <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_HLT) begin
                        r_regnum <= '0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_regnum <= onehot(r_ir[4:3]);
                        r_regce  <= w_regce;
                        r_acce   <= w_acce;
                        r_aluop  <= w_aluop;
                        r_imm    <= w_imm;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_regnum <= '0;
                    r_regce  <= 1'b0;
                    r_acce   <= 1'b0;
                    r_aluop  <= ALU_PASS_REG;
                    r_imm    <= '0;
                    r_req    <= 1'b1;
                    r_state  <= S_FETCH;
`ifdef ID_JMP_EN
                    if (w_op == OP_JMP) begin
                        r_pc <= w_jmp_tgt;
                    end
`endif
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign fetch.instr_req = r_req;
    assign fetch.pc        = r_pc;
    assign RegNum          = r_regnum;
    assign RegCE           = r_regce;
    assign AccCE           = r_acce;
    assign AluOp           = r_aluop;
    assign Imm             = r_imm;
    assign halted          = r_halted;

    a_single_strobe: assert property (@(posedge clk) disable iff (!nReset)
        !(RegCE && AccCE));

    a_halt_quiet: assert property (@(posedge clk) disable iff (!nReset)
        halted |-> (!fetch.instr_req && !RegCE && !AccCE && (RegNum == 4'b0000)));

endmodule
